// File: rtl/alu_pkg.sv
// Shared constants for the ALU control stage: instruction classes, ALU operation
// codes (including the M-type ops) and the sequencer FSM state type.
package alu_pkg;

    localparam logic [2:0] OPC_R   = 3'b000;
    localparam logic [2:0] OPC_I   = 3'b001;
    localparam logic [2:0] OPC_S   = 3'b010;
    localparam logic [2:0] OPC_L   = 3'b011;
    localparam logic [2:0] OPC_B   = 3'b100;
    localparam logic [2:0] OPC_J   = 3'b101;
    localparam logic [2:0] OPC_M   = 3'b110;
    localparam logic [2:0] OPC_ILL = 3'b111;

    localparam int ALUOP_BASE_W = 5;

    localparam logic [4:0] ALUOP_AND  = 5'b00000;
    localparam logic [4:0] ALUOP_OR   = 5'b00001;
    localparam logic [4:0] ALUOP_ADD  = 5'b00010;
    localparam logic [4:0] ALUOP_SLT  = 5'b00011;
    localparam logic [4:0] ALUOP_XOR  = 5'b00100;
    localparam logic [4:0] ALUOP_SLTU = 5'b00101;
    localparam logic [4:0] ALUOP_SRL  = 5'b00110;
    localparam logic [4:0] ALUOP_SLL  = 5'b00111;
    localparam logic [4:0] ALUOP_SRA  = 5'b01000;
    localparam logic [4:0] ALUOP_MUL  = 5'b01001;
    localparam logic [4:0] ALUOP_MULH = 5'b01010;
    localparam logic [4:0] ALUOP_DIV  = 5'b01011;
    localparam logic [4:0] ALUOP_REM  = 5'b01100;
    localparam logic [4:0] ALUOP_SUB  = 5'b10010;
    localparam logic [4:0] ALUOP_NONE = 5'b00000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Purely combinational decode of opcode/fun3/fun7 into the ALU operation code,
// an illegal-encoding flag and the multiply/divide class of M-type operations.
module alu_op_decode #(
    parameter int ALUOP_W = 5
) (
    input  logic [2:0]         opcode_i,
    input  logic [2:0]         fun3_i,
    input  logic               fun7_i,
    output logic [ALUOP_W-1:0] aluop_o,
    output logic               illegal_o,
    output logic               is_mul_o,
    output logic               is_div_o
);
    import alu_pkg::*;

    logic [ALUOP_BASE_W-1:0] op5;

    // I-type shares the R-type table but ignores fun7, so 000 is always ADD and 111 always SRL.
    always_comb begin
        op5       = ALUOP_NONE;
        illegal_o = 1'b0;
        is_mul_o  = 1'b0;
        is_div_o  = 1'b0;
        case (opcode_i)
            OPC_R, OPC_I: begin
                case (fun3_i)
                    3'b000: op5 = (opcode_i == OPC_R && fun7_i) ? ALUOP_SUB : ALUOP_ADD;
                    3'b001: op5 = ALUOP_AND;
                    3'b010: op5 = ALUOP_OR;
                    3'b011: op5 = ALUOP_XOR;
                    3'b100: op5 = ALUOP_SLT;
                    3'b101: op5 = ALUOP_SLTU;
                    3'b110: op5 = ALUOP_SLL;
                    3'b111: op5 = (opcode_i == OPC_I || fun7_i) ? ALUOP_SRL : ALUOP_SRA;
                endcase
            end
            OPC_S: op5 = ALUOP_OR;
            OPC_L, OPC_B, OPC_J: op5 = ALUOP_ADD;
            OPC_M: begin
                case (fun3_i)
                    3'b000: begin op5 = ALUOP_MUL;  is_mul_o = 1'b1; end
                    3'b001: begin op5 = ALUOP_MULH; is_mul_o = 1'b1; end
                    3'b100: begin op5 = ALUOP_DIV;  is_div_o = 1'b1; end
                    3'b110: begin op5 = ALUOP_REM;  is_div_o = 1'b1; end
                    default: illegal_o = 1'b1;
                endcase
            end
            default: illegal_o = 1'b1;
        endcase
    end

    assign aluop_o = ALUOP_W'(op5);

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU control stage: registers the decoded ALU op behind valid/ready handshakes and
// holds M-type ops for MUL_LAT/DIV_LAT cycles. Optional perf counters: ALUCTL_PERF_EN.
module alu_op_sequencer #(
    parameter int  ALUOP_W = 5,
    parameter int  MUL_LAT = 4,
    parameter int  DIV_LAT = 16,
    localparam int CNT_W   = $clog2((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT) + 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [2:0]         opcode_i,
    input  logic [2:0]         fun3_i,
    input  logic               fun7_i,
    output logic [ALUOP_W-1:0] aluop_o,
    output logic               alu_start_o,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic               illegal_o
`ifdef ALUCTL_PERF_EN
    ,
    output logic [31:0]        perf_ops_o,
    output logic [31:0]        perf_stall_o
`endif
);
    import alu_pkg::*;

    // A latency below 2 would let the BUSY countdown wrap past zero.
    generate
        if (ALUOP_W < ALUOP_BASE_W) begin : g_chk_aluop_w
            $error("alu_op_sequencer: ALUOP_W must be at least 5");
        end
        if (MUL_LAT < 2 || DIV_LAT < 2) begin : g_chk_lat
            $error("alu_op_sequencer: MUL_LAT and DIV_LAT must be at least 2");
        end
    endgenerate

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    logic [ALUOP_W-1:0] decAluop;
    logic               decIllegal;
    logic               decIsMul;
    logic               decIsDiv;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ALUOP_W-1:0] aluop_q;
    logic               illegal_q;
    logic               rspValid_q;
    logic               aluStart_q;

    logic               accept;
    logic [CNT_W-1:0]   latLoad_d;

    alu_op_decode #(
        .ALUOP_W (ALUOP_W)
    ) u_decode (
        .opcode_i  (opcode_i),
        .fun3_i    (fun3_i),
        .fun7_i    (fun7_i),
        .aluop_o   (decAluop),
        .illegal_o (decIllegal),
        .is_mul_o  (decIsMul),
        .is_div_o  (decIsDiv)
    );

    // In RESP the consumer's ready passes straight through so a new op can follow without a bubble.
    always_comb begin
        case (state_q)
            ST_IDLE: req_ready_o = 1'b1;
            ST_RESP: req_ready_o = rsp_ready_i;
            default: req_ready_o = 1'b0;
        endcase
    end

    assign accept    = req_valid_i && req_ready_o;
    assign latLoad_d = decIsDiv ? DIV_LOAD : MUL_LOAD;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            aluop_q    <= '0;
            illegal_q  <= 1'b0;
            rspValid_q <= 1'b0;
            aluStart_q <= 1'b0;
        end else begin
            aluStart_q <= 1'b0;
            if (accept) begin
                aluop_q   <= decAluop;
                illegal_q <= decIllegal;
                if (decIsMul || decIsDiv) begin
                    state_q    <= ST_BUSY;
                    cnt_q      <= latLoad_d;
                    aluStart_q <= 1'b1;
                    rspValid_q <= 1'b0;
                end else begin
                    state_q    <= ST_RESP;
                    rspValid_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    ST_BUSY: begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q    <= ST_RESP;
                            rspValid_q <= 1'b1;
                        end
                    end
                    ST_RESP: begin
                        if (rsp_ready_i) begin
                            state_q    <= ST_IDLE;
                            rspValid_q <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign aluop_o     = aluop_q;
    assign illegal_o   = illegal_q;
    assign rsp_valid_o = rspValid_q;
    assign alu_start_o = aluStart_q;

`ifdef ALUCTL_PERF_EN
    logic [31:0] perfOps_q;
    logic [31:0] perfStall_q;
    logic [31:0] perfOps_d;
    logic [31:0] perfStall_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        perfOps_d   = perfOps_q;
        perfStall_d = perfStall_q;
        if (rspValid_q && rsp_ready_i && perfOps_q != '1) begin
            perfOps_d = perfOps_q + 32'd1;
        end
        if (rspValid_q && !rsp_ready_i && perfStall_q != '1) begin
            perfStall_d = perfStall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perfOps_q   <= '0;
            perfStall_q <= '0;
        end else begin
            perfOps_q   <= perfOps_d;
            perfStall_q <= perfStall_d;
        end
    end

    assign perf_ops_o   = perfOps_q;
    assign perf_stall_o = perfStall_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: decode vector table, hand-written multi-cycle sequences
// and a randomized run checked against a transaction-level model of the sequencer.
module tb_alu_op_sequencer;

    localparam int ALUOP_W = 5;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 16;

    logic               clk = 1'b0;
    logic               rst_i = 1'b1;
    logic               req_valid_i = 1'b0;
    logic               req_ready_o;
    logic [2:0]         opcode_i = 3'b000;
    logic [2:0]         fun3_i = 3'b000;
    logic               fun7_i = 1'b0;
    logic [ALUOP_W-1:0] aluop_o;
    logic               alu_start_o;
    logic               rsp_valid_o;
    logic               rsp_ready_i = 1'b1;
    logic               illegal_o;
`ifdef ALUCTL_PERF_EN
    logic [31:0]        perf_ops_o;
    logic [31:0]        perf_stall_o;
`endif

    always #5 clk = ~clk;

    alu_op_sequencer #(
        .ALUOP_W (ALUOP_W),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .opcode_i    (opcode_i),
        .fun3_i      (fun3_i),
        .fun7_i      (fun7_i),
        .aluop_o     (aluop_o),
        .alu_start_o (alu_start_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .illegal_o   (illegal_o)
`ifdef ALUCTL_PERF_EN
        ,
        .perf_ops_o   (perf_ops_o),
        .perf_stall_o (perf_stall_o)
`endif
    );

    int checks = 0;
    int failures = 0;
    int t = 0;
    bit modelKnown = 1'b0;

    // Transaction model: one outstanding op, answered a fixed number of cycles after acceptance.
    bit          mPending = 1'b0;
    int          mAcceptAt = 0;
    int          mRespAt = 0;
    bit          mIsM = 1'b0;
    logic [4:0]  mAluop = 5'b0;
    logic        mIll = 1'b0;
    int unsigned mOps = 0;
    int unsigned mStall = 0;

    bit eValid, eReady, eStart;

    logic       sValid, sStart, sReady, sIll;
    logic [4:0] sAluop;
    int         sT;

    typedef struct {
        logic [2:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [4:0] aluop;
        logic       ill;
        int         lat;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h at cycle %0d", name, got, exp, t);
        end
    endtask

    function automatic void refDecode(input logic [2:0] op, input logic [2:0] f3, input logic f7,
                                      output logic [4:0] a, output logic il, output int lat);
        a = 5'b00000;
        il = 1'b0;
        lat = 1;
        if (op == 3'b000 || op == 3'b001) begin
            case (f3)
                3'd0: a = (op == 3'b000 && f7) ? 5'b10010 : 5'b00010;
                3'd1: a = 5'b00000;
                3'd2: a = 5'b00001;
                3'd3: a = 5'b00100;
                3'd4: a = 5'b00011;
                3'd5: a = 5'b00101;
                3'd6: a = 5'b00111;
                default: a = (op == 3'b000 && !f7) ? 5'b01000 : 5'b00110;
            endcase
        end else if (op == 3'b010) begin
            a = 5'b00001;
        end else if (op == 3'b011 || op == 3'b100 || op == 3'b101) begin
            a = 5'b00010;
        end else if (op == 3'b110 && f3 == 3'd0) begin
            a = 5'b01001; lat = MUL_LAT;
        end else if (op == 3'b110 && f3 == 3'd1) begin
            a = 5'b01010; lat = MUL_LAT;
        end else if (op == 3'b110 && f3 == 3'd4) begin
            a = 5'b01011; lat = DIV_LAT;
        end else if (op == 3'b110 && f3 == 3'd6) begin
            a = 5'b01100; lat = DIV_LAT;
        end else begin
            il = 1'b1;
        end
    endfunction

    task automatic checkOutput();
        check("rsp_valid", 32'(sValid), 32'(eValid));
        check("req_ready", 32'(sReady), 32'(eReady));
        check("alu_start", 32'(sStart), 32'(eStart));
        check("aluop", 32'(sAluop), 32'(mAluop));
        check("illegal", 32'(sIll), 32'(mIll));
`ifdef ALUCTL_PERF_EN
        check("perf_ops", perf_ops_o, mOps);
        check("perf_stall", perf_stall_o, mStall);
`endif
    endtask

    task automatic modelEdge();
        logic [4:0] a;
        logic       il;
        int         lat;
        if (rst_i) begin
            mPending = 1'b0;
            mAluop = 5'b0;
            mIll = 1'b0;
            mOps = 0;
            mStall = 0;
            modelKnown = 1'b1;
        end else if (modelKnown) begin
            if (eValid) begin
                if (rsp_ready_i) mOps++;
                else mStall++;
            end
            if (req_valid_i && eReady) begin
                refDecode(opcode_i, fun3_i, fun7_i, a, il, lat);
                mPending = 1'b1;
                mAcceptAt = t;
                mRespAt = t + lat;
                mIsM = (lat > 1);
                mAluop = a;
                mIll = il;
            end else if (eValid && rsp_ready_i) begin
                mPending = 1'b0;
            end
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit rv, input logic [2:0] op,
                                 input logic [2:0] f3, input bit f7, input bit rr);
        @(negedge clk);
        rst_i = rst;
        req_valid_i = rv;
        opcode_i = op;
        fun3_i = f3;
        fun7_i = f7;
        rsp_ready_i = rr;
        #1;
        sValid = rsp_valid_o;
        sStart = alu_start_o;
        sReady = req_ready_o;
        sIll = illegal_o;
        sAluop = aluop_o;
        sT = t;
        eValid = mPending && (t >= mRespAt);
        eStart = mPending && mIsM && (t == mAcceptAt + 1);
        eReady = !mPending ? 1'b1 : (eValid ? rr : 1'b0);
        if (modelKnown) checkOutput();
        modelEdge();
        t++;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 40 && mPending; i++) applyStimulus(0, 0, 3'd0, 3'd0, 0, 1);
        check("wait_idle_timeout", 32'(mPending), 32'd0);
    endtask

    task automatic runVector(input int idx);
        int  accT;
        bit  found;
        waitIdle();
        applyStimulus(0, 1, vecs[idx].op, vecs[idx].f3, vecs[idx].f7, 1);
        accT = sT;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0, 0, 3'd0, 3'd0, 0, 1);
            if (sValid) begin
                found = 1'b1;
                break;
            end
        end
        check($sformatf("vec%0d_rsp_seen", idx), 32'(found), 32'd1);
        if (found) begin
            check($sformatf("vec%0d_aluop", idx), 32'(sAluop), 32'(vecs[idx].aluop));
            check($sformatf("vec%0d_illegal", idx), 32'(sIll), 32'(vecs[idx].ill));
            check($sformatf("vec%0d_latency", idx), 32'(sT - accT), 32'(vecs[idx].lat));
        end
    endtask

    initial begin
        int startCnt;
        int startT;
        int accT;
        int validCnt;
        bit found;

        vecs[0]  = '{3'b000, 3'b000, 1'b0, 5'b00010, 1'b0, 1};
        vecs[1]  = '{3'b000, 3'b000, 1'b1, 5'b10010, 1'b0, 1};
        vecs[2]  = '{3'b000, 3'b111, 1'b1, 5'b00110, 1'b0, 1};
        vecs[3]  = '{3'b000, 3'b111, 1'b0, 5'b01000, 1'b0, 1};
        vecs[4]  = '{3'b000, 3'b110, 1'b0, 5'b00111, 1'b0, 1};
        vecs[5]  = '{3'b000, 3'b011, 1'b1, 5'b00100, 1'b0, 1};
        vecs[6]  = '{3'b000, 3'b101, 1'b0, 5'b00101, 1'b0, 1};
        vecs[7]  = '{3'b001, 3'b000, 1'b1, 5'b00010, 1'b0, 1};
        vecs[8]  = '{3'b001, 3'b111, 1'b0, 5'b00110, 1'b0, 1};
        vecs[9]  = '{3'b001, 3'b111, 1'b1, 5'b00110, 1'b0, 1};
        vecs[10] = '{3'b010, 3'b011, 1'b0, 5'b00001, 1'b0, 1};
        vecs[11] = '{3'b011, 3'b000, 1'b0, 5'b00010, 1'b0, 1};
        vecs[12] = '{3'b100, 3'b001, 1'b1, 5'b00010, 1'b0, 1};
        vecs[13] = '{3'b101, 3'b110, 1'b0, 5'b00010, 1'b0, 1};
        vecs[14] = '{3'b110, 3'b000, 1'b0, 5'b01001, 1'b0, MUL_LAT};
        vecs[15] = '{3'b110, 3'b001, 1'b0, 5'b01010, 1'b0, MUL_LAT};
        vecs[16] = '{3'b110, 3'b100, 1'b0, 5'b01011, 1'b0, DIV_LAT};
        vecs[17] = '{3'b110, 3'b110, 1'b1, 5'b01100, 1'b0, DIV_LAT};
        vecs[18] = '{3'b110, 3'b010, 1'b0, 5'b00000, 1'b1, 1};
        vecs[19] = '{3'b111, 3'b000, 1'b0, 5'b00000, 1'b1, 1};

        applyStimulus(1, 0, 3'd0, 3'd0, 0, 1);
        applyStimulus(1, 0, 3'd0, 3'd0, 0, 1);
        applyStimulus(0, 0, 3'd0, 3'd0, 0, 1);
        check("reset_ready", 32'(sReady), 32'd1);
        check("reset_valid", 32'(sValid), 32'd0);
        check("reset_aluop", 32'(sAluop), 32'd0);

        for (int i = 0; i < 20; i++) runVector(i);

        // ADD then SUB back-to-back with no bubble
        waitIdle();
        applyStimulus(0, 1, 3'b000, 3'b000, 0, 1);
        applyStimulus(0, 1, 3'b000, 3'b000, 1, 1);
        check("b2b_first_valid", 32'(sValid), 32'd1);
        check("b2b_first_aluop", 32'(sAluop), 32'h02);
        check("b2b_accept_ready", 32'(sReady), 32'd1);
        applyStimulus(0, 0, 3'd0, 3'd0, 0, 1);
        check("b2b_second_valid", 32'(sValid), 32'd1);
        check("b2b_second_aluop", 32'(sAluop), 32'h12);

        // DIV with a request held pending during BUSY
        waitIdle();
        applyStimulus(0, 1, 3'b110, 3'b100, 0, 1);
        accT = sT;
        startCnt = 0;
        startT = -1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0, 1, 3'b000, 3'b000, 0, 1);
            if (sStart) begin
                startCnt++;
                startT = sT;
            end
            if (sValid) begin
                found = 1'b1;
                break;
            end
            check("div_busy_ready", 32'(sReady), 32'd0);
        end
        check("div_rsp_seen", 32'(found), 32'd1);
        check("div_latency", 32'(sT - accT), 32'(DIV_LAT));
        check("div_aluop", 32'(sAluop), 32'h0B);
        check("div_start_count", 32'(startCnt), 32'd1);
        check("div_start_cycle", 32'(startT - accT), 32'd1);

        // Backpressure for 5 cycles with a new request pending
        applyStimulus(1, 0, 3'd0, 3'd0, 0, 1);
        applyStimulus(0, 1, 3'b000, 3'b000, 0, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 3'b000, 3'b000, 1, 0);
            check("bp_ready_low", 32'(sReady), 32'd0);
            check("bp_aluop_stable", 32'(sAluop), 32'h02);
        end
        applyStimulus(0, 0, 3'd0, 3'd0, 0, 1);
        check("bp_still_valid", 32'(sValid), 32'd1);
        check("bp_aluop_after", 32'(sAluop), 32'h02);
`ifdef ALUCTL_PERF_EN
        check("bp_perf_stall", perf_stall_o, 32'd5);
`endif

        // Reset in the middle of a MUL: the op must vanish
        waitIdle();
        applyStimulus(0, 1, 3'b110, 3'b000, 0, 1);
        applyStimulus(0, 0, 3'd0, 3'd0, 0, 1);
        applyStimulus(0, 0, 3'd0, 3'd0, 0, 1);
        applyStimulus(1, 0, 3'd0, 3'd0, 0, 1);
        validCnt = 0;
        applyStimulus(0, 0, 3'd0, 3'd0, 0, 1);
        check("abort_ready", 32'(sReady), 32'd1);
        check("abort_aluop", 32'(sAluop), 32'd0);
        if (sValid) validCnt++;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 3'd0, 3'd0, 0, 1);
            if (sValid) validCnt++;
        end
        check("abort_no_rsp", 32'(validCnt), 32'd0);

        // Randomized traffic, with occasional resets
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 79) == 0,
                          $urandom_range(0, 1) == 1,
                          ($urandom_range(0, 3) == 0) ? 3'b110 : 3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)),
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
